icb_rr_arbiter: RTL and testbench
=================================

Name: icb_rr_arbiter

Overview:
- Two-master ICB arbiter in front of the single ICB slave port of the ICB-to-APB bridge (dut_top), e.g. CPU and DMA sharing the four APB slaves.
- Command channel: round-robin arbitration with grant lock. Responses come back in order and are routed to the issuing master through an ID FIFO.
- Pure ICB-in/ICB-out; it adds no cycles of latency on either channel.

Parameters:
- ADDR_W, 32, ICB address width
- DATA_W, 32, ICB data width
- MAX_OUTSTD, 4, max accepted-but-unresponded commands (ID FIFO depth, power of two, >=2)

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- mN_cmd_valid  in  1  (N=0,1) master command valid
- mN_cmd_ready  out  1  master command ready
- mN_cmd_addr  in  ADDR_W  address
- mN_cmd_read  in  1  1=read, 0=write
- mN_cmd_wdata  in  DATA_W  write data
- mN_cmd_wmask  in  DATA_W/8  byte mask
- mN_rsp_valid  out  1  response valid
- mN_rsp_ready  in  1  response ready
- mN_rsp_rdata  out  DATA_W  read data
- mN_rsp_err  out  1  error
- s_cmd_valid / s_cmd_ready / s_cmd_addr / s_cmd_read / s_cmd_wdata / s_cmd_wmask  out/in/out/out/out/out  widths as above  to bridge
- s_rsp_valid / s_rsp_ready / s_rsp_rdata / s_rsp_err  in/out/in/in  widths as above  from bridge
- outstd_cnt  out  $clog2(MAX_OUTSTD)+1  current FIFO occupancy (debug)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - All mN_cmd_ready, mN_rsp_valid, s_cmd_valid and s_rsp_ready are 0.
  - outstd_cnt is 0. ID FIFO is empty. Lock is cleared.
  - last_grant resets to 1, so m0 wins the first contest.
- Grant selection (combinational):
  - If lock is set, grant = locked_id.
  - Otherwise, if only one master is valid, grant it.
  - If both are valid, grant the master != last_grant.
- Command mux: s_cmd_* = granted master's fields. s_cmd_valid = granted valid & !fifo_full.
- Ready: mN_cmd_ready = (grant==N) & s_cmd_ready & !fifo_full. The non-granted master always sees ready 0.
- Lock:
  - Set when s_cmd_valid=1 and s_cmd_ready=0; locked_id = grant.
  - Cleared on the command handshake.
  - Guarantees the command presented downstream stays stable until accepted.
- On command handshake: push grant into the ID FIFO, last_grant <= grant, lock cleared.
- Full FIFO:
  - s_cmd_valid is forced to 0 and commands stall.
  - A push is refused even if a pop occurs the same cycle; the command is accepted the following cycle.
- Response routing:
  - head = FIFO head ID.
  - m[head]_rsp_valid = s_rsp_valid & !fifo_empty.
  - s_rsp_ready = m[head]_rsp_ready & !fifo_empty.
  - mN_rsp_rdata and mN_rsp_err are driven from s_rsp_* to both masters. Only the valid qualifies them.
  - Pop on the s_rsp handshake.
- Empty FIFO with s_rsp_valid=1 is a protocol violation: s_rsp_ready stays 0 and the bench flags it with an assertion.
- Simultaneous push and pop (not full): occupancy unchanged, both pointers advance.
- Latency: 0 cycles combinational on both channels. No data registering.
- Reset mid-transaction: FIFO, lock and last_grant are cleared at once. Outstanding responses are discarded. Downstream must be reset together.

Decomposition:
- icb_arb_pkg:
  - ADDR_W and DATA_W defaults.
  - typedef logic mid_t (master ID).
  - typedef struct icb_cmd_t {addr, read, wdata, wmask}.
  - typedef struct icb_rsp_t {rdata, err}.
- Sub-module icb_arb_id_fifo:
  - Synchronous FIFO, parameters MAX_OUTSTD and width 1.
  - Outputs: full, empty, count, head.
  - Uses the same clk/rst.

Test Plan:
- Single master: m0 issues a write to 0x1000_0000 with wdata 0xA5A5_A5A5, then a read. Required: each command passes through the same cycle; responses return on m0 only; m1_rsp_valid stays 0 throughout.
- Contention: m0 and m1 both hold valid for 4 back-to-back accepts with s_cmd_ready=1. Required: grant order m0, m1, m0, m1, and the FIFO contents match.
- Lock: both masters valid, s_cmd_ready held 0 for 3 cycles. Required: s_cmd_addr stays m0's address all 3 cycles; m0 is accepted when ready rises.
- Outstanding limit: issue 5 commands with no responses and MAX_OUTSTD=4. Required: the 5th stalls with outstd_cnt=4. Then one response is popped while the 5th is pending. Required: the 5th is accepted on the cycle after the pop.
- Response ordering and backpressure: issue m1 read then m0 read; m1_rsp_ready=0 for 2 cycles. Required: s_rsp_ready=0 during those cycles, m0 receives nothing until m1's response completes, then rdata routes in order.
- Async reset with outstd_cnt=3. Required: outstd_cnt becomes 0 and all valid/ready outputs go 0 without waiting for a clock; after release, m0 wins the first contest.

Source files
------------

// File: rtl/icb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : icb_arb_pkg
//  Purpose  : Shared types and default widths for the two-master ICB arbiter.
//             mid_t identifies the issuing master (0 = m0, 1 = m1).
//             The command/response structs bundle one ICB beat at the
//             default widths.
//  Revision : 1.0 - initial release
// ============================================================================
package icb_arb_pkg;

   localparam int ICB_ADDR_W = 32;
   localparam int ICB_DATA_W = 32;

   typedef logic mid_t;

   typedef struct packed {
      logic [ICB_ADDR_W-1:0]   addr;
      logic                    read;
      logic [ICB_DATA_W-1:0]   wdata;
      logic [ICB_DATA_W/8-1:0] wmask;
   } icb_cmd_t;

   typedef struct packed {
      logic [ICB_DATA_W-1:0] rdata;
      logic                  err;
   } icb_rsp_t;

endpackage : icb_arb_pkg
`default_nettype wire

// File: rtl/icb_arb_id_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : icb_arb_id_fifo
//  Purpose  : Synchronous FIFO of master IDs, one entry per accepted but
//             not yet answered command. The head tells the arbiter which
//             master owns the next response.
//  Ports    : clk, rst     - clock, asynchronous active-high reset
//             i_push       - write i_push_id (ignored when full)
//             i_pop        - drop the head entry (ignored when empty)
//             o_full       - MAX_OUTSTD entries held
//             o_empty      - no entries held
//             o_count      - current occupancy
//             o_head       - ID at the read pointer
//  Revision : 1.0 - initial release
// ============================================================================
module icb_arb_id_fifo
   import icb_arb_pkg::*;
#(
   parameter int MAX_OUTSTD = 4,
   parameter int CNT_W      = $clog2(MAX_OUTSTD) + 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  mid_t             i_push_id,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count,
   output mid_t             o_head
);

   localparam int c_ptr_w = $clog2(MAX_OUTSTD);

   logic [MAX_OUTSTD-1:0] r_mem;
   logic [c_ptr_w-1:0]    r_wr_ptr;
   logic [c_ptr_w-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic                  w_push;
   logic                  w_pop;

   assign o_full  = (r_count == CNT_W'(MAX_OUTSTD));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   // Full is judged on the registered count, so a pop in the same cycle
   // does not open a slot for a push until the next cycle.
   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop  & ~o_empty;

   // Depth is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_id;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : icb_arb_id_fifo
`default_nettype wire

// File: rtl/icb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : icb_rr_arbiter
//  Purpose  : Two-master ICB arbiter feeding a single ICB slave port.
//             Round-robin command arbitration with a grant lock that holds
//             a stalled command stable, and in-order response routing
//             through an ID FIFO. Both channels are purely combinational.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             mN_cmd_*          - master N command channel (N = 0, 1)
//             mN_rsp_*          - master N response channel
//             s_cmd_*           - command channel to the bridge
//             s_rsp_*           - response channel from the bridge
//             outstd_cnt        - commands accepted but not yet answered
//  Revision : 1.0 - initial release
// ============================================================================
module icb_rr_arbiter
   import icb_arb_pkg::*;
#(
   parameter int ADDR_W     = ICB_ADDR_W,
   parameter int DATA_W     = ICB_DATA_W,
   parameter int MAX_OUTSTD = 4
)(
   input  logic                       clk,
   input  logic                       rst,
   // master 0
   input  logic                       m0_cmd_valid,
   output logic                       m0_cmd_ready,
   input  logic [ADDR_W-1:0]          m0_cmd_addr,
   input  logic                       m0_cmd_read,
   input  logic [DATA_W-1:0]          m0_cmd_wdata,
   input  logic [DATA_W/8-1:0]        m0_cmd_wmask,
   output logic                       m0_rsp_valid,
   input  logic                       m0_rsp_ready,
   output logic [DATA_W-1:0]          m0_rsp_rdata,
   output logic                       m0_rsp_err,
   // master 1
   input  logic                       m1_cmd_valid,
   output logic                       m1_cmd_ready,
   input  logic [ADDR_W-1:0]          m1_cmd_addr,
   input  logic                       m1_cmd_read,
   input  logic [DATA_W-1:0]          m1_cmd_wdata,
   input  logic [DATA_W/8-1:0]        m1_cmd_wmask,
   output logic                       m1_rsp_valid,
   input  logic                       m1_rsp_ready,
   output logic [DATA_W-1:0]          m1_rsp_rdata,
   output logic                       m1_rsp_err,
   // slave side
   output logic                       s_cmd_valid,
   input  logic                       s_cmd_ready,
   output logic [ADDR_W-1:0]          s_cmd_addr,
   output logic                       s_cmd_read,
   output logic [DATA_W-1:0]          s_cmd_wdata,
   output logic [DATA_W/8-1:0]        s_cmd_wmask,
   input  logic                       s_rsp_valid,
   output logic                       s_rsp_ready,
   input  logic [DATA_W-1:0]          s_rsp_rdata,
   input  logic                       s_rsp_err,
   // debug
   output logic [$clog2(MAX_OUTSTD):0] outstd_cnt
);

   localparam int c_cnt_w = $clog2(MAX_OUTSTD) + 1;

   mid_t               r_last_grant;
   logic               r_lock;
   mid_t               r_lock_id;

   mid_t               w_grant;
   logic               w_fifo_full;
   logic               w_fifo_empty;
   mid_t               w_head;
   logic [c_cnt_w-1:0] w_count;
   logic               w_cmd_ok;
   logic               w_ready_ok;
   logic               w_rsp_ok;
   logic               w_cmd_hs;
   logic               w_rsp_hs;

   // ------------------------------------------------------------------
   // Grant selection. With nobody valid the choice is irrelevant; the
   // round-robin default keeps the logic minimal.
   // ------------------------------------------------------------------
   always_comb begin
      w_grant = ~r_last_grant;
      if (r_lock) begin
         w_grant = r_lock_id;
      end else if (m0_cmd_valid && !m1_cmd_valid) begin
         w_grant = 1'b0;
      end else if (m1_cmd_valid && !m0_cmd_valid) begin
         w_grant = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Command channel. Reset also gates the handshake outputs so they
   // drop immediately on assertion, not at the next clock.
   // ------------------------------------------------------------------
   assign w_cmd_ok   = ~rst & ~w_fifo_full;
   assign w_ready_ok = w_cmd_ok & s_cmd_ready;

   assign s_cmd_valid  = w_cmd_ok & (w_grant ? m1_cmd_valid : m0_cmd_valid);
   assign s_cmd_addr   = w_grant ? m1_cmd_addr  : m0_cmd_addr;
   assign s_cmd_read   = w_grant ? m1_cmd_read  : m0_cmd_read;
   assign s_cmd_wdata  = w_grant ? m1_cmd_wdata : m0_cmd_wdata;
   assign s_cmd_wmask  = w_grant ? m1_cmd_wmask : m0_cmd_wmask;

   assign m0_cmd_ready = w_ready_ok & (w_grant == 1'b0);
   assign m1_cmd_ready = w_ready_ok & (w_grant == 1'b1);

   assign w_cmd_hs = s_cmd_valid & s_cmd_ready;

   // ------------------------------------------------------------------
   // Response channel: the FIFO head names the owner of the response.
   // With an empty FIFO any response is unsolicited and is not accepted.
   // ------------------------------------------------------------------
   assign w_rsp_ok = ~rst & ~w_fifo_empty;

   assign m0_rsp_valid = w_rsp_ok & s_rsp_valid & (w_head == 1'b0);
   assign m1_rsp_valid = w_rsp_ok & s_rsp_valid & (w_head == 1'b1);
   assign s_rsp_ready  = w_rsp_ok & (w_head ? m1_rsp_ready : m0_rsp_ready);

   assign m0_rsp_rdata = s_rsp_rdata;
   assign m0_rsp_err   = s_rsp_err;
   assign m1_rsp_rdata = s_rsp_rdata;
   assign m1_rsp_err   = s_rsp_err;

   assign w_rsp_hs = s_rsp_valid & s_rsp_ready;

   // ------------------------------------------------------------------
   // Round-robin history and grant lock. A presented-but-stalled command
   // freezes the grant so the downstream view cannot change under it.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant <= 1'b1;
         r_lock       <= 1'b0;
         r_lock_id    <= 1'b0;
      end else begin
         if (w_cmd_hs) begin
            r_last_grant <= w_grant;
            r_lock       <= 1'b0;
         end else if (s_cmd_valid && !s_cmd_ready) begin
            r_lock       <= 1'b1;
            r_lock_id    <= w_grant;
         end
      end
   end

   icb_arb_id_fifo #(
      .MAX_OUTSTD (MAX_OUTSTD),
      .CNT_W      (c_cnt_w)
   ) u_id_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_cmd_hs),
      .i_push_id (w_grant),
      .i_pop     (w_rsp_hs),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty),
      .o_count   (w_count),
      .o_head    (w_head)
   );

   assign outstd_cnt = w_count;

endmodule : icb_rr_arbiter
`default_nettype wire

// File: tb/tb_icb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icb_rr_arbiter
//  Purpose  : Directed self-checking bench for icb_rr_arbiter. The bench
//             plays both masters and the bridge; expected values are
//             hand-computed constants.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icb_rr_arbiter;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int MAX_OUTSTD = 4;
   localparam int CNT_W      = $clog2(MAX_OUTSTD) + 1;

   localparam logic [ADDR_W-1:0] A0 = 32'h1000_0000;
   localparam logic [ADDR_W-1:0] A1 = 32'h2000_0000;

   logic                clk = 1'b0;
   logic                rst;

   logic                m0_cmd_valid, m0_cmd_ready, m0_cmd_read;
   logic [ADDR_W-1:0]   m0_cmd_addr;
   logic [DATA_W-1:0]   m0_cmd_wdata;
   logic [DATA_W/8-1:0] m0_cmd_wmask;
   logic                m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
   logic [DATA_W-1:0]   m0_rsp_rdata;

   logic                m1_cmd_valid, m1_cmd_ready, m1_cmd_read;
   logic [ADDR_W-1:0]   m1_cmd_addr;
   logic [DATA_W-1:0]   m1_cmd_wdata;
   logic [DATA_W/8-1:0] m1_cmd_wmask;
   logic                m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
   logic [DATA_W-1:0]   m1_rsp_rdata;

   logic                s_cmd_valid, s_cmd_ready, s_cmd_read;
   logic [ADDR_W-1:0]   s_cmd_addr;
   logic [DATA_W-1:0]   s_cmd_wdata;
   logic [DATA_W/8-1:0] s_cmd_wmask;
   logic                s_rsp_valid, s_rsp_ready, s_rsp_err;
   logic [DATA_W-1:0]   s_rsp_rdata;
   logic [CNT_W-1:0]    outstd_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   icb_rr_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .MAX_OUTSTD (MAX_OUTSTD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .m0_cmd_valid (m0_cmd_valid),
      .m0_cmd_ready (m0_cmd_ready),
      .m0_cmd_addr  (m0_cmd_addr),
      .m0_cmd_read  (m0_cmd_read),
      .m0_cmd_wdata (m0_cmd_wdata),
      .m0_cmd_wmask (m0_cmd_wmask),
      .m0_rsp_valid (m0_rsp_valid),
      .m0_rsp_ready (m0_rsp_ready),
      .m0_rsp_rdata (m0_rsp_rdata),
      .m0_rsp_err   (m0_rsp_err),
      .m1_cmd_valid (m1_cmd_valid),
      .m1_cmd_ready (m1_cmd_ready),
      .m1_cmd_addr  (m1_cmd_addr),
      .m1_cmd_read  (m1_cmd_read),
      .m1_cmd_wdata (m1_cmd_wdata),
      .m1_cmd_wmask (m1_cmd_wmask),
      .m1_rsp_valid (m1_rsp_valid),
      .m1_rsp_ready (m1_rsp_ready),
      .m1_rsp_rdata (m1_rsp_rdata),
      .m1_rsp_err   (m1_rsp_err),
      .s_cmd_valid  (s_cmd_valid),
      .s_cmd_ready  (s_cmd_ready),
      .s_cmd_addr   (s_cmd_addr),
      .s_cmd_read   (s_cmd_read),
      .s_cmd_wdata  (s_cmd_wdata),
      .s_cmd_wmask  (s_cmd_wmask),
      .s_rsp_valid  (s_rsp_valid),
      .s_rsp_ready  (s_rsp_ready),
      .s_rsp_rdata  (s_rsp_rdata),
      .s_rsp_err    (s_rsp_err),
      .outstd_cnt   (outstd_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---------------- reset state (outputs gated while in reset) -------
      rst          = 1'b1;
      m0_cmd_valid = 1'b1;  m0_cmd_addr = A0; m0_cmd_read = 1'b0;
      m0_cmd_wdata = '0;    m0_cmd_wmask = 4'hF; m0_rsp_ready = 1'b1;
      m1_cmd_valid = 1'b0;  m1_cmd_addr = A1; m1_cmd_read = 1'b1;
      m1_cmd_wdata = '0;    m1_cmd_wmask = 4'h0; m1_rsp_ready = 1'b1;
      s_cmd_ready  = 1'b1;  s_rsp_valid = 1'b1; s_rsp_rdata = '0; s_rsp_err = 1'b0;
      #2;
      chk("rst_cnt",        outstd_cnt,   0);
      chk("rst_s_cmd_vld",  s_cmd_valid,  0);
      chk("rst_m0_cmd_rdy", m0_cmd_ready, 0);
      chk("rst_m1_cmd_rdy", m1_cmd_ready, 0);
      chk("rst_s_rsp_rdy",  s_rsp_ready,  0);
      chk("rst_m0_rsp_vld", m0_rsp_valid, 0);
      chk("rst_m1_rsp_vld", m1_rsp_valid, 0);
      m0_cmd_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      // Unsolicited response with empty FIFO must not be accepted.
      chk("empty_s_rsp_rdy",  s_rsp_ready,  0);
      chk("empty_m0_rsp_vld", m0_rsp_valid, 0);
      chk("empty_m1_rsp_vld", m1_rsp_valid, 0);
      s_rsp_valid = 1'b0;

      // ---------------- contention: m0, m1, m0, m1 -----------------------
      m0_cmd_valid = 1'b1;
      m1_cmd_valid = 1'b1;
      s_cmd_ready  = 1'b1;
      m0_rsp_ready = 1'b0;
      m1_rsp_ready = 1'b0;
      #1;
      chk("rr0_addr",   s_cmd_addr,   A0);
      chk("rr0_m0_rdy", m0_cmd_ready, 1);
      chk("rr0_m1_rdy", m1_cmd_ready, 0);
      tick();
      chk("rr1_addr",   s_cmd_addr,   A1);
      chk("rr1_m1_rdy", m1_cmd_ready, 1);
      chk("rr1_m0_rdy", m0_cmd_ready, 0);
      tick();
      chk("rr2_addr",   s_cmd_addr,   A0);
      tick();
      chk("rr3_addr",   s_cmd_addr,   A1);
      tick();

      // ---------------- full FIFO stalls the 5th command -----------------
      chk("full_cnt",    outstd_cnt,   4);
      chk("full_s_vld",  s_cmd_valid,  0);
      chk("full_m0_rdy", m0_cmd_ready, 0);
      chk("full_m1_rdy", m1_cmd_ready, 0);
      tick();
      chk("full_cnt_hold", outstd_cnt, 4);
      // Pop one response (head = m0) while the 5th is pending.
      s_rsp_valid  = 1'b1;
      s_rsp_rdata  = 32'hAAAA_0000;
      m0_rsp_ready = 1'b1;
      #1;
      chk("pop_m0_vld",  m0_rsp_valid, 1);
      chk("pop_s_rdy",   s_rsp_ready,  1);
      chk("pop_s_cvld",  s_cmd_valid,  0);
      tick();
      s_rsp_valid  = 1'b0;
      #1;
      chk("after_pop_cnt",  outstd_cnt,   3);
      chk("fifth_s_vld",    s_cmd_valid,  1);
      chk("fifth_addr",     s_cmd_addr,   A0);
      chk("fifth_m0_rdy",   m0_cmd_ready, 1);
      tick();
      chk("fifth_cnt", outstd_cnt, 4);
      m0_cmd_valid = 1'b0;
      m1_cmd_valid = 1'b0;

      // FIFO now holds m1, m0, m1, m0.
      s_rsp_valid  = 1'b1;
      m0_rsp_ready = 1'b1;
      m1_rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("drain%0d_m1_vld", i), m1_rsp_valid, (i % 2 == 0) ? 1 : 0);
         chk($sformatf("drain%0d_m0_vld", i), m0_rsp_valid, (i % 2 == 0) ? 0 : 1);
         tick();
      end
      s_rsp_valid = 1'b0;
      chk("drain_cnt", outstd_cnt, 0);

      // ---------------- single master m0: write then read ----------------
      m0_cmd_valid = 1'b1;
      m0_cmd_addr  = A0;
      m0_cmd_read  = 1'b0;
      m0_cmd_wdata = 32'hA5A5_A5A5;
      m0_cmd_wmask = 4'hF;
      #1;
      chk("sm_wr_vld",   s_cmd_valid,  1);
      chk("sm_wr_addr",  s_cmd_addr,   A0);
      chk("sm_wr_read",  s_cmd_read,   0);
      chk("sm_wr_wdata", s_cmd_wdata,  32'hA5A5_A5A5);
      chk("sm_wr_wmask", s_cmd_wmask,  4'hF);
      chk("sm_wr_rdy",   m0_cmd_ready, 1);
      tick();
      m0_cmd_read = 1'b1;
      #1;
      chk("sm_rd_read", s_cmd_read,   1);
      chk("sm_rd_rdy",  m0_cmd_ready, 1);
      tick();
      m0_cmd_valid = 1'b0;
      chk("sm_cnt", outstd_cnt, 2);
      s_rsp_valid = 1'b1;
      s_rsp_rdata = '0;
      s_rsp_err   = 1'b0;
      #1;
      chk("sm_rsp0_m0_vld", m0_rsp_valid, 1);
      chk("sm_rsp0_m1_vld", m1_rsp_valid, 0);
      tick();
      s_rsp_rdata = 32'hC0DE_0001;
      s_rsp_err   = 1'b1;
      #1;
      chk("sm_rsp1_m0_vld",   m0_rsp_valid, 1);
      chk("sm_rsp1_m1_vld",   m1_rsp_valid, 0);
      chk("sm_rsp1_m0_rdata", m0_rsp_rdata, 32'hC0DE_0001);
      chk("sm_rsp1_m0_err",   m0_rsp_err,   1);
      tick();
      s_rsp_valid = 1'b0;
      s_rsp_err   = 1'b0;
      chk("sm_done_cnt", outstd_cnt, 0);

      // ---------------- ordering and backpressure ------------------------
      m1_cmd_valid = 1'b1;
      #1;
      chk("ord_m1_rdy", m1_cmd_ready, 1);
      tick();
      m1_cmd_valid = 1'b0;
      m0_cmd_valid = 1'b1;
      #1;
      chk("ord_m0_rdy", m0_cmd_ready, 1);
      tick();
      m0_cmd_valid = 1'b0;
      s_rsp_valid  = 1'b1;
      s_rsp_rdata  = 32'h1111_1111;
      m1_rsp_ready = 1'b0;
      m0_rsp_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk($sformatf("bp%0d_s_rdy", i),  s_rsp_ready,  0);
         chk($sformatf("bp%0d_m1_vld", i), m1_rsp_valid, 1);
         chk($sformatf("bp%0d_m0_vld", i), m0_rsp_valid, 0);
         tick();
      end
      chk("bp_cnt", outstd_cnt, 2);
      m1_rsp_ready = 1'b1;
      #1;
      chk("ord1_s_rdy",    s_rsp_ready,  1);
      chk("ord1_m1_rdata", m1_rsp_rdata, 32'h1111_1111);
      tick();
      s_rsp_rdata = 32'h2222_2222;
      #1;
      chk("ord2_m0_vld",   m0_rsp_valid, 1);
      chk("ord2_m1_vld",   m1_rsp_valid, 0);
      chk("ord2_m0_rdata", m0_rsp_rdata, 32'h2222_2222);
      tick();
      s_rsp_valid = 1'b0;
      chk("ord_cnt", outstd_cnt, 0);

      // ---------------- lock overrides round-robin ------------------------
      // last grant is m0; m0 presents alone into a stalled slave, then m1
      // joins. Without the lock the round-robin would switch to m1.
      m0_cmd_valid = 1'b1;
      s_cmd_ready  = 1'b0;
      tick();
      m1_cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("lk%0d_addr", i), s_cmd_addr,  A0);
         chk($sformatf("lk%0d_vld", i),  s_cmd_valid, 1);
         tick();
      end
      s_cmd_ready = 1'b1;
      #1;
      chk("lk_m0_rdy", m0_cmd_ready, 1);
      chk("lk_m1_rdy", m1_cmd_ready, 0);
      tick();
      chk("lk_next_addr", s_cmd_addr, A1);
      tick();
      tick();
      chk("pre_rst_cnt", outstd_cnt, 3);

      // ---------------- asynchronous reset mid-transaction ---------------
      s_rsp_valid  = 1'b1;
      rst          = 1'b1;
      #1;
      chk("arst_cnt",       outstd_cnt,   0);
      chk("arst_s_cmd_vld", s_cmd_valid,  0);
      chk("arst_m0_rdy",    m0_cmd_ready, 0);
      chk("arst_m1_rdy",    m1_cmd_ready, 0);
      chk("arst_s_rsp_rdy", s_rsp_ready,  0);
      chk("arst_m0_rsp",    m0_rsp_valid, 0);
      chk("arst_m1_rsp",    m1_rsp_valid, 0);
      tick();
      rst         = 1'b0;
      s_rsp_valid = 1'b0;
      s_cmd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("post%0d_addr", i), s_cmd_addr,   A0);
         chk($sformatf("post%0d_rdy", i),  m0_cmd_ready, 0);
         tick();
      end
      s_cmd_ready = 1'b1;
      #1;
      chk("post_m0_rdy", m0_cmd_ready, 1);
      chk("post_m1_rdy", m1_cmd_ready, 0);
      tick();
      chk("post_cnt",  outstd_cnt, 1);
      chk("post_addr", s_cmd_addr, A1);

      m0_cmd_valid = 1'b0;
      m1_cmd_valid = 1'b0;
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_icb_rr_arbiter
`default_nettype wire
